pc_fetch_sequencer: RTL
=======================

# pc_fetch_sequencer

Fetch/retire controller that owns the program counter of the RISC-V core and sequences every PC update. It issues instruction-memory requests at the current PC and holds the fetched instruction for the datapath until the datapath signals completion. On completion it selects the next PC (sequential, redirect, trap) and counts retired instructions. It sits between the instruction memory port and the execute datapath.

## Interface
Parameters:
- N, 32, PC/address width
- RESET_PC, 32'h0040_0000, PC loaded on reset
- TRAP_PC, 32'h0040_0004, PC loaded on misaligned redirect
- TIMEOUT, 16, fetch-wait limit in cycles (used only with PC_FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state changes on posedge clk
- reset  in  1  synchronous, active-high; takes effect on the posedge where it is high
- imem_req  out  1  fetch request, held high while in FETCH
- imem_addr  out  N  fetch address, always equals pc
- imem_ack  in  1  instruction memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- instr  out  32  latched instruction
- instr_valid  out  1  high throughout EXEC
- exec_done  in  1  datapath completed instr; sampled only in EXEC
- redirect  in  1  taken branch/jump for the current instruction
- redirect_target  in  N  next PC when redirect=1
- halt  in  1  ecall/ebreak; stop after this instruction
- pc  out  N  current PC
- pc_plus4  out  N  pc + 4, modulo 2^N
- misalign  out  1  one-cycle pulse on misaligned redirect
- halted  out  1  high in HALT
- retire_count  out  32  retired-instruction counter
- bus_err  out  1  sticky fetch-timeout flag (0 when macro undefined)

## Operation
- States: FETCH, EXEC, HALT. Reset state FETCH.
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=1 (FETCH), misalign=0, halted=0, retire_count=0, bus_err=0.
- FETCH: imem_req=1. On imem_ack: instr<=imem_rdata; go to EXEC. exec_done ignored.
- EXEC: instr_valid=1, imem_req=0; imem_ack ignored. On exec_done, retire_count += 1 (wraps at 2^32) and:
  - halt=1 (highest priority): pc unchanged; go to HALT. redirect ignored.
  - else redirect=1 with redirect_target[1:0]==0: pc<=redirect_target; go to FETCH.
  - else redirect=1 with redirect_target[1:0]!=0: pc<=TRAP_PC; misalign=1 for one cycle; go to FETCH.
  - else: pc<=pc+4 (wraps 32'hFFFF_FFFC -> 0); go to FETCH.
- HALT: halted=1, imem_req=0, instr_valid=0; exit only by reset.
- reset=1 overrides every simultaneous input (ack, exec_done, halt).

## Timing
- Fetch latency: imem_req asserted the first cycle after reset deasserts; instr_valid rises the cycle after the imem_ack cycle.
- Zero-wait memory (ack in the first FETCH cycle) plus same-cycle exec_done gives a 2-cycle-per-instruction minimum: FETCH, EXEC.
- pc, retire_count, misalign update on the exec_done edge. The new imem_addr is visible the following cycle.
- pc_plus4 is combinational from pc.
- imem_addr must not change while imem_req=1.

## Configuration
- PC_FETCH_TIMEOUT_EN defined:
  - A wait counter clears on entry to FETCH and increments each FETCH cycle without imem_ack.
  - When it reaches TIMEOUT without ack: bus_err<=1 (sticky until reset); go to HALT.
- Undefined: no counter; FETCH waits indefinitely; bus_err tied to 0.

## Test plan
- Reset, then ack with rdata=32'h0000_0013 on the 3rd FETCH cycle, exec_done 1 cycle later -> imem_addr=32'h0040_0000, instr=32'h13, then pc=32'h0040_0004, retire_count=1.
- exec_done with redirect=1, target=32'h0040_0100 -> next imem_addr=32'h0040_0100. Same with target=32'h0040_0102 -> pc=TRAP_PC, misalign pulses once.
- exec_done with halt=1 and redirect=1 together -> HALT, pc unchanged, retire_count incremented, imem_req=0 until reset.
- Sequential retire from pc=32'hFFFF_FFFC -> pc=0. retire_count preset near 32'hFFFF_FFFF wraps to 0.
- reset asserted in EXEC together with exec_done -> next cycle FETCH, pc=RESET_PC, retire_count=0; exec_done in FETCH and imem_ack in EXEC have no effect.
- With PC_FETCH_TIMEOUT_EN, no ack for 16 cycles -> bus_err=1, halted=1. Without the macro, FETCH holds for 100 cycles with bus_err=0.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner: fetches at pc, holds the instruction until the datapath retires it,
// then picks the next pc. Optional fetch timeout is enabled with PC_FETCH_TIMEOUT_EN.
module pc_fetch_sequencer #(
    parameter int unsigned   N        = 32,
    parameter logic [N-1:0]  RESET_PC = 32'h0040_0000,
    parameter logic [N-1:0]  TRAP_PC  = 32'h0040_0004,
    parameter int unsigned   TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr,
    output logic         instr_valid,
    input  logic         exec_done,
    input  logic         redirect,
    input  logic [N-1:0] redirect_target,
    input  logic         halt,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus4,
    output logic         misalign,
    output logic         halted,
    output logic [31:0]  retire_count,
    output logic         bus_err
);

    typedef enum logic [1:0] {StFetch, StExec, StHalt} state_t;

    state_t state;

    assign imem_addr = pc;
    assign pc_plus4  = pc + N'(4);

`ifdef PC_FETCH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] wait_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StFetch;
            pc           <= RESET_PC;
            instr        <= 32'h0;
            instr_valid  <= 1'b0;
            imem_req     <= 1'b1;
            misalign     <= 1'b0;
            halted       <= 1'b0;
            retire_count <= 32'h0;
`ifdef PC_FETCH_TIMEOUT_EN
            wait_cnt     <= '0;
            bus_err      <= 1'b0;
`endif
        end else begin
            misalign <= 1'b0;
            unique case (state)
                StFetch: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= StExec;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
`ifdef PC_FETCH_TIMEOUT_EN
                    end else if (wait_cnt == CntW'(TIMEOUT - 1)) begin
                        // Memory never answered: give up and park the core.
                        bus_err  <= 1'b1;
                        state    <= StHalt;
                        imem_req <= 1'b0;
                        halted   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CntW'(1);
`endif
                    end
                end
                StExec: begin
                    if (exec_done) begin
                        retire_count <= retire_count + 32'd1;
                        instr_valid  <= 1'b0;
                        if (halt) begin
                            state  <= StHalt;
                            halted <= 1'b1;
                        end else begin
                            state    <= StFetch;
                            imem_req <= 1'b1;
`ifdef PC_FETCH_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                            if (redirect && (redirect_target[1:0] == 2'b00)) begin
                                pc <= redirect_target;
                            end else if (redirect) begin
                                pc       <= TRAP_PC;
                                misalign <= 1'b1;
                            end else begin
                                pc <= pc_plus4;
                            end
                        end
                    end
                end
                StHalt: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: state <= StFetch;
            endcase
        end
    end

endmodule
